// File: rtl/mips_ctrl_pkg.sv
// Shared control-word definitions for the MIPS ID/EX boundary.
// Holds control-field widths, ALUOp codes, load/store size encodings,
// the packed control word and the all-zero bubble constant.
package mips_ctrl_pkg;

    localparam int ALUOP_W = 6;
    localparam int SEL_W   = 2;
    localparam int REG_W   = 5;

    // ALUOp codes produced by the decoder
    localparam logic [ALUOP_W-1:0] ALUOP_NOP = 6'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 6'd21;
    localparam logic [ALUOP_W-1:0] ALUOP_LW  = 6'd43;
    localparam logic [ALUOP_W-1:0] ALUOP_SW  = 6'd46;
    localparam logic [ALUOP_W-1:0] ALUOP_BEQ = 6'd49;

    // MuxLoad / MuxStore access-size encodings
    localparam logic [SEL_W-1:0] MUX_WORD = 2'd0;
    localparam logic [SEL_W-1:0] MUX_HALF = 2'd1;
    localparam logic [SEL_W-1:0] MUX_BYTE = 2'd2;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic [SEL_W-1:0]   reg_dst;
        logic [SEL_W-1:0]   alu_src0;
        logic [SEL_W-1:0]   alu_src1;
        logic [SEL_W-1:0]   mux_store;
        logic [SEL_W-1:0]   mux_load;
        logic [SEL_W-1:0]   mem_reg;
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               jump_control;
        logic               jreg_control;
    } ctrl_word_t;

    localparam int CTRL_W = $bits(ctrl_word_t);

    // A bubble is a NOP with every strobe and select forced to hard zero
    localparam ctrl_word_t CTRL_BUBBLE = ctrl_word_t'({ALUOP_NOP, {(CTRL_W-ALUOP_W){1'b0}}});

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Load-use hazard term: the instruction in EX is a real load whose
// destination (Rt, non-zero) matches either source field of the ID
// instruction. Both fields are compared regardless of format.
module load_use_detect
    import mips_ctrl_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);

    logic rt_nonzero_s;
    logic rt_match_s;

    // Combinational comparison of the EX load destination against ID sources
    always_comb begin
        rt_nonzero_s = (ex_rt != 5'd0);
        rt_match_s   = (ex_rt == id_rs) || (ex_rt == id_rt);
        if (ex_valid && ex_mem_read && rt_nonzero_s && rt_match_s) begin
            hazard = 1'b1;
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Captures the decoded control word and ID operands each edge, inserts
// bubbles on Flush or load-use hazard, and freezes on Hold.
// Build option: define ID_EX_HAZARD_EN to enable load-use detection;
// without it, Stall is tied low and software must schedule NOPs after loads.
module id_ex_pipe_reg
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              Hold,
    input  logic [5:0]        ID_ALUOp,
    input  logic [1:0]        ID_RegDst,
    input  logic [1:0]        ID_ALUSrc0,
    input  logic [1:0]        ID_ALUSrc1,
    input  logic [1:0]        ID_MuxStore,
    input  logic [1:0]        ID_MuxLoad,
    input  logic [1:0]        ID_MemReg,
    input  logic              ID_Branch,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_RegWrite,
    input  logic              ID_JumpControl,
    input  logic              ID_JRegControl,
    input  logic [DATA_W-1:0] ID_PCPlus4,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_SignExt,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [4:0]        ID_Shamt,
    output logic [5:0]        EX_ALUOp,
    output logic [1:0]        EX_RegDst,
    output logic [1:0]        EX_ALUSrc0,
    output logic [1:0]        EX_ALUSrc1,
    output logic [1:0]        EX_MuxStore,
    output logic [1:0]        EX_MuxLoad,
    output logic [1:0]        EX_MemReg,
    output logic              EX_Branch,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_RegWrite,
    output logic              EX_JumpControl,
    output logic              EX_JRegControl,
    output logic [DATA_W-1:0] EX_PCPlus4,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_SignExt,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic [4:0]        EX_Shamt,
    output logic              EX_Valid,
    output logic              Stall
);

    ctrl_word_t        id_ctrl_s;
    ctrl_word_t        ctrl_r;
    ctrl_word_t        ctrl_nxt_s;
    logic [DATA_W-1:0] pc_plus4_r, pc_plus4_nxt_s;
    logic [DATA_W-1:0] rd1_r, rd1_nxt_s;
    logic [DATA_W-1:0] rd2_r, rd2_nxt_s;
    logic [DATA_W-1:0] sign_ext_r, sign_ext_nxt_s;
    logic [4:0]        rs_r, rs_nxt_s;
    logic [4:0]        rt_r, rt_nxt_s;
    logic [4:0]        rd_r, rd_nxt_s;
    logic [4:0]        shamt_r, shamt_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic              hazard_s;

    // Pack the decoder outputs into a control word; X fields pass through untouched
    always_comb begin
        id_ctrl_s.alu_op       = ID_ALUOp;
        id_ctrl_s.reg_dst      = ID_RegDst;
        id_ctrl_s.alu_src0     = ID_ALUSrc0;
        id_ctrl_s.alu_src1     = ID_ALUSrc1;
        id_ctrl_s.mux_store    = ID_MuxStore;
        id_ctrl_s.mux_load     = ID_MuxLoad;
        id_ctrl_s.mem_reg      = ID_MemReg;
        id_ctrl_s.branch       = ID_Branch;
        id_ctrl_s.mem_read     = ID_MemRead;
        id_ctrl_s.mem_write    = ID_MemWrite;
        id_ctrl_s.reg_write    = ID_RegWrite;
        id_ctrl_s.jump_control = ID_JumpControl;
        id_ctrl_s.jreg_control = ID_JRegControl;
    end

`ifdef ID_EX_HAZARD_EN
    load_use_detect u_load_use_detect (
        .ex_valid    (valid_r),
        .ex_mem_read (ctrl_r.mem_read),
        .ex_rt       (rt_r),
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .hazard      (hazard_s)
    );
`else
    assign hazard_s = 1'b0;
`endif

    // Upstream freeze only when this stage owns it: Flush and Hold both override
    assign Stall = hazard_s & ~Flush & ~Hold;

    // Next-state selection in priority order: Flush, Hold, hazard, normal load
    always_comb begin
        ctrl_nxt_s     = ctrl_r;
        valid_nxt_s    = valid_r;
        pc_plus4_nxt_s = pc_plus4_r;
        rd1_nxt_s      = rd1_r;
        rd2_nxt_s      = rd2_r;
        sign_ext_nxt_s = sign_ext_r;
        rs_nxt_s       = rs_r;
        rt_nxt_s       = rt_r;
        rd_nxt_s       = rd_r;
        shamt_nxt_s    = shamt_r;
        if (Hold && !Flush) begin
            ctrl_nxt_s  = ctrl_r;
            valid_nxt_s = valid_r;
        end else begin
            // Data word always follows ID; it is don't-care under a bubble
            pc_plus4_nxt_s = ID_PCPlus4;
            rd1_nxt_s      = ID_ReadData1;
            rd2_nxt_s      = ID_ReadData2;
            sign_ext_nxt_s = ID_SignExt;
            rs_nxt_s       = ID_Rs;
            rt_nxt_s       = ID_Rt;
            rd_nxt_s       = ID_Rd;
            shamt_nxt_s    = ID_Shamt;
            if (Flush || hazard_s) begin
                ctrl_nxt_s  = CTRL_BUBBLE;
                valid_nxt_s = 1'b0;
            end else begin
                ctrl_nxt_s  = id_ctrl_s;
                valid_nxt_s = 1'b1;
            end
        end
    end

    // EX-stage state flops with asynchronous clear to a bubble
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ctrl_r     <= CTRL_BUBBLE;
            valid_r    <= 1'b0;
            pc_plus4_r <= {DATA_W{1'b0}};
            rd1_r      <= {DATA_W{1'b0}};
            rd2_r      <= {DATA_W{1'b0}};
            sign_ext_r <= {DATA_W{1'b0}};
            rs_r       <= 5'd0;
            rt_r       <= 5'd0;
            rd_r       <= 5'd0;
            shamt_r    <= 5'd0;
        end else begin
            ctrl_r     <= ctrl_nxt_s;
            valid_r    <= valid_nxt_s;
            pc_plus4_r <= pc_plus4_nxt_s;
            rd1_r      <= rd1_nxt_s;
            rd2_r      <= rd2_nxt_s;
            sign_ext_r <= sign_ext_nxt_s;
            rs_r       <= rs_nxt_s;
            rt_r       <= rt_nxt_s;
            rd_r       <= rd_nxt_s;
            shamt_r    <= shamt_nxt_s;
        end
    end

    assign EX_ALUOp       = ctrl_r.alu_op;
    assign EX_RegDst      = ctrl_r.reg_dst;
    assign EX_ALUSrc0     = ctrl_r.alu_src0;
    assign EX_ALUSrc1     = ctrl_r.alu_src1;
    assign EX_MuxStore    = ctrl_r.mux_store;
    assign EX_MuxLoad     = ctrl_r.mux_load;
    assign EX_MemReg      = ctrl_r.mem_reg;
    assign EX_Branch      = ctrl_r.branch;
    assign EX_MemRead     = ctrl_r.mem_read;
    assign EX_MemWrite    = ctrl_r.mem_write;
    assign EX_RegWrite    = ctrl_r.reg_write;
    assign EX_JumpControl = ctrl_r.jump_control;
    assign EX_JRegControl = ctrl_r.jreg_control;
    assign EX_PCPlus4     = pc_plus4_r;
    assign EX_ReadData1   = rd1_r;
    assign EX_ReadData2   = rd2_r;
    assign EX_SignExt     = sign_ext_r;
    assign EX_Rs          = rs_r;
    assign EX_Rt          = rt_r;
    assign EX_Rd          = rd_r;
    assign EX_Shamt       = shamt_r;
    assign EX_Valid       = valid_r;

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register for the 5-stage MIPS datapath. It sits directly downstream of the instruction decoder/controller and captures the decoded control word and the ID-stage operands on each clock edge. It also detects load-use hazards, inserts bubbles, and honours branch/jump flushes and downstream holds. All EX-stage consumers (ALU, ALU controller, source muxes, forwarding unit) read only its registered outputs.

## Interface
- DATA_W, 32, datapath width (PC+4, register operands, sign-extended immediate)
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset
- Flush  in  1  branch/jump taken; squash the instruction entering EX
- Hold  in  1  downstream freeze; keep all EX outputs unchanged
- ID_ALUOp  in  6  decoded operation code
- ID_RegDst, ID_ALUSrc0, ID_ALUSrc1, ID_MuxStore, ID_MuxLoad, ID_MemReg  in  2 each  decoded mux selects
- ID_Branch, ID_MemRead, ID_MemWrite, ID_RegWrite, ID_JumpControl, ID_JRegControl  in  1 each  decoded strobes
- ID_PCPlus4, ID_ReadData1, ID_ReadData2, ID_SignExt  in  DATA_W each  ID-stage data
- ID_Rs, ID_Rt, ID_Rd, ID_Shamt  in  5 each  instruction fields
- EX_* (one per ID_* input above)  out  same width  registered copies
- EX_Valid  out  1  EX holds a real (non-bubble) instruction
- Stall  out  1  freeze PC and IF/ID this cycle (load-use)

## Operation
- The control word is every 1-/2-/6-bit control input. The data word is PC+4, the two operands, SignExt, and the four register fields.
- Bubble: control word all zero (ALUOp=0 is NOP, all strobes 0), EX_Valid=0. The data word captures its ID values and is don't-care.
- The decoder drives X on don't-care control fields. The register captures those values unmodified. Bubbles are forced to hard 0, never X.
- Load-use hazard: hazard = EX_Valid & EX_MemRead & (EX_Rt != 0) & (EX_Rt == ID_Rs | EX_Rt == ID_Rt). Both fields are compared regardless of instruction format; this is a conservative check.
- Stall = hazard & ~Flush & ~Hold.
- Per-edge update, in priority order:
  - Rst low: all EX_* outputs 0, EX_Valid=0.
  - Flush: load a bubble.
  - Hold: retain all EX_* outputs.
  - hazard: load a bubble. The ID instruction is preserved upstream by Stall.
  - else: load the ID words and set EX_Valid=1.
- A load-use stall lasts exactly one cycle: the bubble clears EX_MemRead, so the hazard term falls on the next cycle.
- Flush together with hazard: flush wins, Stall=0, and the bubble is loaded.
- Hold together with hazard: Stall=0, because the upstream freeze is owned by the Hold source. The hazard re-evaluates after Hold drops.
- Rst deasserted mid-operation: the pipeline restarts with a bubble in EX. Stall=0 while EX_Valid=0.

## Timing
- Latency: one Clk from ID_* to EX_*. All EX_* outputs are flops.
- Stall is combinational from EX_* flops and ID_Rs/ID_Rt, valid in the same cycle. There is no path from Flush/Hold to EX_* except through the flops.
- Reset value of every output is 0, including Stall (because EX_Valid=0).
- Asynchronous assert; release is synchronised upstream.

## Configuration
- ID_EX_HAZARD_EN defined: load-use detection as above.
- ID_EX_HAZARD_EN undefined:
  - Stall is tied to 0 and hazard is treated as 0.
  - Software must schedule a NOP after every load.
  - Flush and Hold behaviour is unchanged.

## Structure
- Shared package mips_ctrl_pkg holds:
  - control-field widths;
  - ALUOp constants (ALUOP_NOP=0, ALUOP_LW=43, ALUOP_SW=46, ALUOP_BEQ=49, …);
  - MuxLoad/MuxStore encodings (WORD=0, HALF=1, BYTE=2);
  - a packed ctrl_word_t struct and a CTRL_BUBBLE constant.
- One sub-module, load_use_detect: a combinational hazard term, instantiated only under ID_EX_HAZARD_EN.

## Test plan
- Reset: hold Rst=0 with random ID inputs -> all EX_* = 0, Stall=0. Release Rst, present add (ALUOp=21) -> EX_ALUOp=21, EX_Valid=1 one edge later.
- Load-use: lw $5 (ALUOp=43, Rt=5) then add with Rs=5 -> Stall=1 for exactly one cycle; EX shows bubble (ALUOp=0, RegWrite=0); add reaches EX on the following edge.
- No false hazard: lw to Rt=0, then an instruction with Rs=0 -> Stall=0. lw Rt=7, next Rs=3/Rt=4 -> Stall=0.
- Flush priority: Flush=1 in the same cycle as a load-use hazard -> Stall=0, EX bubble, EX_MemWrite=0.
- Hold: Hold=1 for 3 cycles while ID changes -> EX_* frozen at the prior sw (ALUOp=46, MemWrite=1). Stall=0 throughout.
- Macro off: repeat the load-use stimulus without ID_EX_HAZARD_EN -> Stall stays 0; add enters EX on the next edge.
